// File: rtl/yas_egress_merger.sv
// yas_egress_merger: packet-aware 3:1 round-robin merger onto one valid/ready stream.
// Ports: clk, rst_n (async low), ch_data/ch_req/ch_ack (per-channel byte streams),
//   crc_en (trailing CRC byte), out_data/out_valid/out_ready/out_last/out_ch, pkt_done.
module yas_egress_merger #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3*DATA_WIDTH-1:0] ch_data,
    input  logic [2:0]              ch_req,
    output logic [2:0]              ch_ack,
    input  logic                    crc_en,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [1:0]              out_ch,
    output logic                    pkt_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_BODY
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_rr;
    logic [1:0]            w_rr_nxt;
    logic [1:0]            r_grant;
    logic [1:0]            w_grant_nxt;
    logic [DATA_SIZE:0]    r_remain;
    logic [DATA_SIZE:0]    w_remain_nxt;
    logic [DATA_SIZE:0]    w_hdr_len;
    logic [DATA_WIDTH-1:0] w_byte;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [1:0]            r_out_ch;
    logic                  w_load;
    logic                  w_xfer;
    logic                  w_last;
    logic [1:0]            w_c1;
    logic [1:0]            w_c2;
    logic [1:0]            w_pick;

    function automatic logic [1:0] f_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Output register can take a new byte when empty or being drained.
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_byte = ch_data[0 +: DATA_WIDTH];
        case (r_grant)
            2'd1:    w_byte = ch_data[DATA_WIDTH +: DATA_WIDTH];
            2'd2:    w_byte = ch_data[2*DATA_WIDTH +: DATA_WIDTH];
            default: w_byte = ch_data[0 +: DATA_WIDTH];
        endcase
    end

    // Header length field plus optional CRC byte; one extra bit so it cannot wrap.
    assign w_hdr_len = (DATA_SIZE+1)'(w_byte[DATA_WIDTH-1:2])
                     + (DATA_SIZE+1)'(crc_en);

    // Round-robin search starts just after the last served channel.
    always_comb begin
        w_c1   = f_inc(r_rr);
        w_c2   = f_inc(w_c1);
        w_pick = r_rr;
        if (ch_req[w_c1]) begin
            w_pick = w_c1;
        end else if (ch_req[w_c2]) begin
            w_pick = w_c2;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr;
        w_remain_nxt = r_remain;
        w_xfer       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|ch_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (ch_req[r_grant] && w_load) begin
                    w_xfer = 1'b1;
                    if (w_hdr_len == '0) begin
                        w_last      = 1'b1;
                        w_rr_nxt    = r_grant;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_remain_nxt = w_hdr_len;
                        w_state_nxt  = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (ch_req[r_grant] && w_load) begin
                    w_xfer = 1'b1;
                    if (r_remain == (DATA_SIZE+1)'(1)) begin
                        w_last       = 1'b1;
                        w_remain_nxt = '0;
                        w_rr_nxt     = r_grant;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_remain_nxt = r_remain - (DATA_SIZE+1)'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ch_ack = w_xfer ? (3'b001 << r_grant) : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr     <= 2'd2;
            r_grant  <= 2'd0;
            r_remain <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= 2'd0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_byte;
            r_out_last  <= w_last;
            r_out_ch    <= r_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;
    assign pkt_done  = r_out_valid && out_ready && r_out_last;

endmodule

// File: tb/tb_yas_egress_merger.sv
// tb_yas_egress_merger: directed bench for the 3:1 packet merger.
// Channel queues feed ch_*, a monitor collects accepted output bytes.
module tb_yas_egress_merger;

    logic        clk;
    logic        rst_n;
    logic [23:0] ch_data;
    logic [2:0]  ch_req;
    logic [2:0]  ch_ack;
    logic        crc_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        pkt_done;

    yas_egress_merger #(.DATA_WIDTH(8), .DATA_SIZE(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_data   (ch_data),
        .ch_req    (ch_req),
        .ch_ack    (ch_ack),
        .crc_en    (crc_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .pkt_done  (pkt_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mem [3][256];
    int          rd [3] = '{0, 0, 0};
    int          wr [3] = '{0, 0, 0};
    logic [2:0]  hold = 3'b000;
    logic        flush = 1'b0;
    logic        tog = 1'b0;

    logic [10:0] rec_q [$];
    logic [10:0] exp_q [$];
    int          pkt_cnt = 0;
    int          base;
    int          pkt_base;

    assign ch_data[0 +: 8]  = mem[0][rd[0]];
    assign ch_data[8 +: 8]  = mem[1][rd[1]];
    assign ch_data[16 +: 8] = mem[2][rd[2]];
    assign ch_req[0] = (rd[0] != wr[0]) && !hold[0];
    assign ch_req[1] = (rd[1] != wr[1]) && !hold[1];
    assign ch_req[2] = (rd[2] != wr[2]) && !hold[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Channel driver: pop bytes acknowledged in the previous cycle.
    initial begin
        logic [2:0] acks;
        forever begin
            @(negedge clk);
            acks = ch_ack & ch_req;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (flush) rd[i] = wr[i];
                else if (acks[i]) rd[i] = rd[i] + 1;
            end
        end
    end

    // Downstream ready: constant 1 or alternating.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) out_ready = ~out_ready;
            else out_ready = 1'b1;
        end
    end

    // Output monitor: latency, stall stability, ack legality, capture.
    initial begin
        logic        px;
        logic        ps;
        logic [1:0]  pch;
        logic [7:0]  pdat;
        logic [11:0] sv;
        px = 1'b0;
        ps = 1'b0;
        pch = 2'd0;
        pdat = 8'd0;
        sv = 12'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                px = 1'b0;
                ps = 1'b0;
            end else begin
                if (px)
                    chk("latency", {out_valid, out_ch, out_data}, {1'b1, pch, pdat});
                if (ps)
                    chk("stall_hold", {out_valid, out_last, out_ch, out_data}, sv);
                chk("ack_req", ch_ack & ~ch_req, 3'b000);
                chk("ack_onehot", 32'($onehot0(ch_ack)), 1);
                if (out_valid && out_ready) rec_q.push_back({out_ch, out_last, out_data});
                if (pkt_done) pkt_cnt++;
                px = |ch_ack;
                pch = ch_ack[1] ? 2'd1 : (ch_ack[2] ? 2'd2 : 2'd0);
                pdat = ch_data[pch*8 +: 8];
                ps = out_valid && !out_ready;
                sv = {out_valid, out_last, out_ch, out_data};
            end
        end
    end

    task automatic push(input int c, input logic [7:0] b);
        mem[c][wr[c]] = b;
        wr[c] = wr[c] + 1;
    endtask

    task automatic expb(input logic [1:0] c, input logic l, input logic [7:0] d);
        exp_q.push_back({c, l, d});
    endtask

    task automatic start_test();
        exp_q.delete();
        base = rec_q.size();
        pkt_base = pkt_cnt;
    endtask

    task automatic wait_recs(input int budget);
        int k = 0;
        while ((rec_q.size() - base) < exp_q.size() && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic compare(input string tag, input int npk);
        chk({tag, "_count"}, rec_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rec_q.size())
                chk($sformatf("%s_rec%0d", tag, i), rec_q[base+i], exp_q[i]);
        end
        chk({tag, "_pkt_done"}, pkt_cnt - pkt_base, npk);
    endtask

    initial begin
        int k;
        int b0;
        rst_n = 1'b0;
        crc_en = 1'b0;

        // Reset with all channels requesting, then round-robin of 1-byte packets.
        start_test();
        push(0, 8'h01);
        push(1, 8'h02);
        push(2, 8'h03);
        push(0, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("rst_req", ch_req, 3'b111);
            chk("rst_out", {out_valid, out_last, out_ch, out_data, pkt_done}, 0);
            chk("rst_ack", ch_ack, 3'b000);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        expb(2'd0, 1'b1, 8'h01);
        expb(2'd1, 1'b1, 8'h02);
        expb(2'd2, 1'b1, 8'h03);
        expb(2'd0, 1'b1, 8'h00);
        wait_recs(200);
        compare("rr", 4);

        // Single ch1 packet, len=3, no CRC.
        start_test();
        push(1, 8'h0D);
        push(1, 8'hA1);
        push(1, 8'hA2);
        push(1, 8'hA3);
        expb(2'd1, 1'b0, 8'h0D);
        expb(2'd1, 1'b0, 8'hA1);
        expb(2'd1, 1'b0, 8'hA2);
        expb(2'd1, 1'b1, 8'hA3);
        wait_recs(200);
        compare("single", 1);

        // ch0 len=5 with CRC, downstream ready alternating.
        start_test();
        crc_en = 1'b1;
        tog = 1'b1;
        push(0, 8'h16);
        expb(2'd0, 1'b0, 8'h16);
        for (int i = 1; i <= 5; i++) begin
            push(0, 8'(8'h40 + i));
            expb(2'd0, 1'b0, 8'(8'h40 + i));
        end
        push(0, 8'hCC);
        expb(2'd0, 1'b1, 8'hCC);
        wait_recs(400);
        tog = 1'b0;
        crc_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        compare("crc_tog", 1);

        // Granted ch0 drops req mid-body while ch2 waits.
        start_test();
        b0 = rd[0];
        push(0, 8'h10);
        for (int i = 1; i <= 4; i++) push(0, 8'(8'h50 + i));
        k = 0;
        while (rd[0] - b0 < 3 && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("stall_reach", rd[0] - b0, 3);
        hold[0] = 1'b1;
        push(2, 8'h07);
        push(2, 8'hC5);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ack", ch_ack, 3'b000);
        end
        @(posedge clk);
        #2;
        hold[0] = 1'b0;
        expb(2'd0, 1'b0, 8'h10);
        expb(2'd0, 1'b0, 8'h51);
        expb(2'd0, 1'b0, 8'h52);
        expb(2'd0, 1'b0, 8'h53);
        expb(2'd0, 1'b1, 8'h54);
        expb(2'd2, 1'b0, 8'h07);
        expb(2'd2, 1'b1, 8'hC5);
        wait_recs(400);
        compare("stall", 2);

        // Reset in the middle of a len=10 packet, then a clean packet.
        b0 = rd[1];
        push(1, 8'h28);
        for (int i = 1; i <= 10; i++) push(1, 8'(8'h60 + i));
        k = 0;
        while (rd[1] - b0 < 2 && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("abort_reach", rd[1] - b0, 2);
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        chk("abort_out", {out_valid, out_last, out_ch, out_data, pkt_done}, 0);
        chk("abort_ack", ch_ack, 3'b000);
        repeat (2) @(posedge clk);
        #3;
        flush = 1'b0;
        chk("abort_flush", ch_req, 3'b000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        start_test();
        push(2, 8'h09);
        push(2, 8'hB1);
        push(2, 8'hB2);
        expb(2'd2, 1'b0, 8'h09);
        expb(2'd2, 1'b0, 8'hB1);
        expb(2'd2, 1'b1, 8'hB2);
        wait_recs(200);
        compare("after_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
